// File: rtl/serial_sub_if.sv
// Handshake/bus interface for serial_sub.
//   master : operand producer / result consumer (drives in_valid, a, b, bin, out_ready)
//   slave  : serial_sub itself (drives in_ready, out_valid, diff, bout[, ovf])
// Optional: SERIAL_SUB_OVF_EN adds the ovf signed-overflow flag.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow
// flop, one bit per clock, LSB first. diff = (a - b - bin) mod 2^WIDTH,
// bout = 1 iff a < b + bin (unsigned).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_sub_if.slave (in_valid/in_ready/a/b/bin in,
//           out_valid/out_ready/diff/bout out)
// Optional: define SERIAL_SUB_OVF_EN to add bus.ovf, the two's-complement
// signed overflow flag, valid with out_valid.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] d_sr_q;
    logic             br_q;
    logic             bout_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             d_c;
    logic             bo_c;
    logic             last_c;

    // Full-subtractor cell on the current LSBs
    assign d_c    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    assign bo_c   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    assign last_c = (cnt_q == CW'(WIDTH - 1));

    // Control FSM and datapath; bout_q is separate from br_q so the visible
    // borrow only moves on shift updates, not when bin is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            d_sr_q      <= '0;
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_q     <= bus.a;
                        b_sr_q     <= bus.b;
                        br_q       <= bus.bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_sr_q <= {d_c, d_sr_q[WIDTH-1:1]};
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    br_q   <= bo_c;
                    bout_q <= bo_c;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_c) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Sign capture at load; overflow resolved with the final (MSB) diff bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
        end else if (state_q == SHIFT && last_c) begin
            ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_c);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = d_sr_q;
    assign bus.bout      = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_sub_if #(.WIDTH(W)) sif ();

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits up to a bounded number of edges for out_valid; returns edges counted
    task automatic wait_valid(output int n);
        n = 0;
        while (sif.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input string nm);
        int n;
        @(negedge clk);
        chk({nm, ".in_ready"}, 32'(sif.in_ready), 32'd1);
        sif.a = a; sif.b = b; sif.bin = bin; sif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        wait_valid(n);
        chk({nm, ".latency"}, 32'(n), 32'(W));
        chk({nm, ".diff"}, 32'(sif.diff), 32'(ed));
        chk({nm, ".bout"}, 32'(sif.bout), 32'(eb));
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;
        chk({nm, ".ov_clr"}, 32'(sif.out_valid), 32'd0);
        chk({nm, ".rdy_back"}, 32'(sif.in_ready), 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0; sif.out_ready = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        vecs[6] = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};

        #12;
        chk("rst.in_ready", 32'(sif.in_ready), 32'd1);
        chk("rst.out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst.diff", 32'(sif.diff), 32'd0);
        chk("rst.bout", 32'(sif.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst.ovf", 32'(sif.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb, $sformatf("vec%0d", i));

        // Backpressure in DONE with new operands offered
        @(negedge clk);
        sif.a = 8'h33; sif.b = 8'h11; sif.bin = 1'b0; sif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.a = 8'hAA; sif.b = 8'h01;
        wait_valid(n);
        chk("hold.latency", 32'(n), 32'(W));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d.out_valid", i), 32'(sif.out_valid), 32'd1);
            chk($sformatf("hold%0d.diff", i), 32'(sif.diff), 32'h22);
            chk($sformatf("hold%0d.bout", i), 32'(sif.bout), 32'd0);
            chk($sformatf("hold%0d.in_ready", i), 32'(sif.in_ready), 32'd0);
        end
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;
        chk("hold.idle_rdy", 32'(sif.in_ready), 32'd1);
        chk("hold.idle_ov", 32'(sif.out_valid), 32'd0);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        chk("hold.accept", 32'(sif.in_ready), 32'd0);
        wait_valid(n);
        chk("hold2.latency", 32'(n), 32'(W));
        chk("hold2.diff", 32'(sif.diff), 32'hA9);
        chk("hold2.bout", 32'(sif.bout), 32'd0);
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;

        // Reset during the third SHIFT cycle
        @(negedge clk);
        sif.a = 8'hF0; sif.b = 8'h0F; sif.bin = 1'b0; sif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.in_ready", 32'(sif.in_ready), 32'd1);
        chk("arst.out_valid", 32'(sif.out_valid), 32'd0);
        chk("arst.diff", 32'(sif.diff), 32'd0);
        chk("arst.bout", 32'(sif.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "post_rst");

`ifdef SERIAL_SUB_OVF_EN
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "ovf0");
        chk("ovf0.ovf_after", 32'(sif.ovf), 32'd1);
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, "ovf1");
        chk("ovf1.ovf_after", 32'(sif.ovf), 32'd1);
        do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "ovf2");
        chk("ovf2.ovf_after", 32'(sif.ovf), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
